// File: rtl/sprite_types_pkg.sv
// sprite_types: shared types for the sprite pipeline in the clk_draw domain.
//   active_tilemap_addr_t : matcher entry, tilemap half (x_flip, tile_count, tilemap_addr)
//   active_bitmap_addr_t  : matcher entry, bitmap half (lb_addr screen x, tile_bitmap_addr)
//   tilemap_entry_t       : one tilemap word as seen by the fetcher (palette, tile)
//   fetch_state_t         : sprite_line_fetcher FSM state, also exported for debug
package sprite_types;

  localparam int MEM_AW_DEF  = 27;
  localparam int TILE_PIXELS = 8;
  localparam int PIXEL_BITS  = 4;
  localparam int TC_W        = 5;   // tile_count width, tile counter uses the same width
  localparam int LB_AW       = 11;
  localparam int IDX_W       = 9;

  typedef struct packed {
    logic                  x_flip;
    logic [TC_W-1:0]       tile_count;
    logic [MEM_AW_DEF-1:0] tilemap_addr;
  } active_tilemap_addr_t;

  typedef struct packed {
    logic [LB_AW-1:0]      lb_addr;
    logic [MEM_AW_DEF-1:0] tile_bitmap_addr;
  } active_bitmap_addr_t;

  typedef struct packed {
    logic [3:0]  palette;
    logic [11:0] tile;
  } tilemap_entry_t;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_SEL   = 3'd1,
    FS_LATCH = 3'd2,
    FS_MAP   = 3'd3,
    FS_BMP   = 3'd4,
    FS_DRAW  = 3'd5,
    FS_DONE  = 3'd6
  } fetch_state_t;

endpackage

// File: rtl/sprite_row_shifter.sv
// sprite_row_shifter: holds one bitmap row word (8 pixels x 4 bits) and the
// sprite's x_flip, and returns the pixel for a draw column. Each pixel covers
// two consecutive columns (pixel doubling).
// Ports:
//   clk_draw, rst_draw : clock, async active-high reset
//   load               : capture row_in / x_flip_in
//   row_in, x_flip_in  : row word and mirror flag
//   col                : draw column 0..15 within the tile
//   pixel              : 4-bit pixel for that column
module sprite_row_shifter
  import sprite_types::*;
(
  input  logic                  clk_draw,
  input  logic                  rst_draw,
  input  logic                  load,
  input  logic [31:0]           row_in,
  input  logic                  x_flip_in,
  input  logic [3:0]            col,
  output logic [PIXEL_BITS-1:0] pixel
);

  logic [31:0] row_q;
  logic        x_flip_q;
  logic [2:0]  p;

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      row_q    <= '0;
      x_flip_q <= 1'b0;
    end else if (load) begin
      row_q    <= row_in;
      x_flip_q <= x_flip_in;
    end
  end

  // col>>1 picks the pixel; mirrored sprites read the row from the top nibble down.
  always_comb begin
    p = col[3:1];
    if (x_flip_q) p = 3'd7 - col[3:1];
    pixel = row_q[{p, 2'b00} +: PIXEL_BITS];
  end

endmodule

// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher: on each line pulse walks the matcher's active list,
// fetches one tilemap word and one bitmap row word per tile, and writes
// pixel-doubled, non-transparent pixels into the sprite line buffer.
// Optional build macro: SPRITE_LINE_FETCHER_OVERRUN_EN adds overrun and
// overrun_count (line pulse arriving while a walk is still in progress).
// Ports:
//   clk_draw, rst_draw       : draw clock, async active-high reset
//   line                     : start-of-line pulse, restarts the walk from any state
//   sprite_index             : active-list index presented to the matcher
//   valid, tilemap_addr,
//   bitmap_addr              : matcher entry, registered one cycle after sprite_index
//   mem_req/addr/ack/rdata   : word read port
//   lb_we, lb_addr, lb_data  : line-buffer write port, data = {palette, pixel}
//   overrun, overrun_count   : (macro only) abort pulse and saturating count
//   state_dbg                : current FSM state
//   busy                     : walk in progress (not IDLE/DONE)
//
// Memory handshake: mem_req is the valid, mem_ack the ready. While mem_req is
// high, mem_addr is stable and the request is held until a cycle with mem_ack;
// that cycle carries mem_rdata and completes the transfer. mem_ack seen without
// mem_req, or in the cycle of a line pulse, is ignored.
module sprite_line_fetcher
  import sprite_types::*;
#(
  parameter int LB_WIDTH = 640,
  parameter int MEM_AW   = MEM_AW_DEF
) (
  input  logic                 clk_draw,
  input  logic                 rst_draw,
  input  logic                 line,
  output logic [IDX_W-1:0]     sprite_index,
  input  logic                 valid,
  input  active_tilemap_addr_t tilemap_addr,
  input  active_bitmap_addr_t  bitmap_addr,
  output logic                 mem_req,
  output logic [MEM_AW-1:0]    mem_addr,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata,
  output logic                 lb_we,
  output logic [LB_AW-1:0]     lb_addr,
  output logic [7:0]           lb_data,
`ifdef SPRITE_LINE_FETCHER_OVERRUN_EN
  output logic                 overrun,
  output logic [15:0]          overrun_count,
`endif
  output fetch_state_t         state_dbg,
  output logic                 busy
);

  localparam logic [11:0] LB_LIMIT = 12'(LB_WIDTH);

  fetch_state_t state, state_nx;

  // Latched matcher entry and per-tile working state
  logic                  x_flip_q;
  logic [TC_W-1:0]       tc_q;
  logic [MEM_AW-1:0]     tmap_q;
  logic [MEM_AW-1:0]     bmp_q;
  logic [LB_AW-1:0]      lb_base_q;
  logic [TC_W-1:0]       t_q;
  logic [3:0]            c_q;
  tilemap_entry_t        ent_q;

  logic [IDX_W-1:0]      idx_inc;
  logic                  last_col;
  logic                  more_tiles;
  logic [TC_W-1:0]       tile_off;
  logic [LB_AW-1:0]      draw_addr;
  logic [PIXEL_BITS-1:0] pixel;
  logic                  row_load;

  assign idx_inc    = sprite_index + 9'd1;
  assign last_col   = (c_q == 4'd15);
  assign more_tiles = ({1'b0, t_q} + 6'd1) < {1'b0, tc_q};
  // Mirrored sprites fetch their tiles right to left.
  assign tile_off   = x_flip_q ? (tc_q - 5'd1 - t_q) : t_q;
  // Wraps at 11 bits; wrapped columns below LB_WIDTH are still drawn.
  assign draw_addr  = lb_base_q + {2'b00, t_q, 4'b0000} + {7'b0000000, c_q};
  assign row_load   = (state == FS_BMP) && mem_ack && !line;
  assign state_dbg  = state;

  sprite_row_shifter u_row (
    .clk_draw  (clk_draw),
    .rst_draw  (rst_draw),
    .load      (row_load),
    .row_in    (mem_rdata),
    .x_flip_in (x_flip_q),
    .col       (c_q),
    .pixel     (pixel)
  );

  // State register
  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) state <= FS_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; line overrides everything
  always_comb begin
    state_nx = state;
    if (line) begin
      state_nx = FS_SEL;
    end else begin
      case (state)
        FS_IDLE:  state_nx = FS_IDLE;
        FS_SEL:   state_nx = FS_LATCH;
        FS_LATCH: begin
          if (!valid)                              state_nx = FS_DONE;
          else if (tilemap_addr.tile_count == '0)  state_nx = (idx_inc == 9'd511) ? FS_DONE : FS_SEL;
          else                                     state_nx = FS_MAP;
        end
        FS_MAP:   if (mem_ack) state_nx = FS_BMP;
        FS_BMP:   if (mem_ack) state_nx = FS_DRAW;
        FS_DRAW: begin
          if (last_col) begin
            if (more_tiles) state_nx = FS_MAP;
            else            state_nx = (idx_inc == 9'd511) ? FS_DONE : FS_SEL;
          end
        end
        FS_DONE:  state_nx = FS_DONE;
        default:  state_nx = FS_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    lb_we    = 1'b0;
    lb_addr  = '0;
    lb_data  = '0;
    busy     = (state != FS_IDLE) && (state != FS_DONE);
    case (state)
      FS_MAP: begin
        mem_req  = 1'b1;
        mem_addr = tmap_q + MEM_AW'(tile_off);
      end
      FS_BMP: begin
        mem_req  = 1'b1;
        mem_addr = bmp_q + MEM_AW'(ent_q.tile);
      end
      FS_DRAW: begin
        lb_addr = draw_addr;
        lb_data = {ent_q.palette, pixel};
        lb_we   = (pixel != '0) && ({1'b0, draw_addr} < LB_LIMIT);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      sprite_index <= '0;
      x_flip_q     <= 1'b0;
      tc_q         <= '0;
      tmap_q       <= '0;
      bmp_q        <= '0;
      lb_base_q    <= '0;
      t_q          <= '0;
      c_q          <= '0;
      ent_q        <= '0;
    end else if (line) begin
      sprite_index <= '0;
    end else begin
      case (state)
        FS_LATCH: begin
          if (valid) begin
            x_flip_q  <= tilemap_addr.x_flip;
            tc_q      <= tilemap_addr.tile_count;
            tmap_q    <= MEM_AW'(tilemap_addr.tilemap_addr);
            bmp_q     <= MEM_AW'(bitmap_addr.tile_bitmap_addr);
            lb_base_q <= bitmap_addr.lb_addr;
            t_q       <= '0;
            if (tilemap_addr.tile_count == '0) sprite_index <= idx_inc;
          end
        end
        FS_MAP: begin
          c_q <= '0;
          if (mem_ack) ent_q <= tilemap_entry_t'(mem_rdata[15:0]);
        end
        FS_DRAW: begin
          c_q <= c_q + 4'd1;
          if (last_col) begin
            if (more_tiles) t_q <= t_q + 5'd1;
            else            sprite_index <= idx_inc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPRITE_LINE_FETCHER_OVERRUN_EN
  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else begin
      overrun <= line && busy;
      if (line && busy && (overrun_count != 16'hFFFF))
        overrun_count <= overrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_line_fetcher.sv
module tb_sprite_line_fetcher;
  import sprite_types::*;

  localparam int LBW = 640;

  // ---------------- clock / reset ----------------
  logic clk_draw = 1'b0;
  logic rst_draw = 1'b0;
  always #5 clk_draw = ~clk_draw;

  logic                 line = 1'b0;
  logic [8:0]           sprite_index;
  logic                 valid;
  active_tilemap_addr_t tilemap_addr;
  active_bitmap_addr_t  bitmap_addr;
  logic                 mem_req;
  logic [26:0]          mem_addr;
  logic                 mem_ack = 1'b0;
  logic [31:0]          mem_rdata = '0;
  logic                 lb_we;
  logic [10:0]          lb_addr;
  logic [7:0]           lb_data;
  fetch_state_t         state_dbg;
  logic                 busy;
`ifdef SPRITE_LINE_FETCHER_OVERRUN_EN
  logic                 overrun;
  logic [15:0]          overrun_count;
`endif

  sprite_line_fetcher #(.LB_WIDTH(LBW), .MEM_AW(27)) dut (
    .clk_draw      (clk_draw),
    .rst_draw      (rst_draw),
    .line          (line),
    .sprite_index  (sprite_index),
    .valid         (valid),
    .tilemap_addr  (tilemap_addr),
    .bitmap_addr   (bitmap_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .lb_we         (lb_we),
    .lb_addr       (lb_addr),
    .lb_data       (lb_data),
`ifdef SPRITE_LINE_FETCHER_OVERRUN_EN
    .overrun       (overrun),
    .overrun_count (overrun_count),
`endif
    .state_dbg     (state_dbg),
    .busy          (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- matcher model (registered read) ----------------
  logic                 m_valid [512];
  active_tilemap_addr_t m_tmap  [512];
  active_bitmap_addr_t  m_bmap  [512];

  always @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      valid        <= 1'b0;
      tilemap_addr <= '0;
      bitmap_addr  <= '0;
    end else begin
      valid        <= m_valid[sprite_index];
      tilemap_addr <= m_tmap[sprite_index];
      bitmap_addr  <= m_bmap[sprite_index];
    end
  end

  // ---------------- memory model + read scoreboard ----------------
  logic [31:0] mem_words [logic [26:0]];
  int          mem_wait   = 0;
  int          wait_cnt   = 0;
  logic        block_en   = 1'b0;
  logic [26:0] block_addr = '0;
  logic [26:0] rd_exp [$];
  logic        req_seen   = 1'b0;
  logic        prev_pend  = 1'b0;
  logic [26:0] prev_addr  = '0;

  function automatic logic [31:0] rd_mem(input logic [26:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return 32'h0;
  endfunction

  always begin
    @(posedge clk_draw);
    #1;
    if (mem_req === 1'b1) req_seen = 1'b1;
    // A pending request must hold level and address unless line/reset intervened.
    if (prev_pend && !line && !rst_draw) begin
      check("mem_req_hold", mem_req, 1'b1);
      check("mem_addr_hold", mem_addr, prev_addr);
    end
    mem_ack = 1'b0;
    if (mem_req === 1'b1 && !(block_en && mem_addr == block_addr)) begin
      if (wait_cnt >= mem_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_mem(mem_addr);
        wait_cnt  = 0;
        if (rd_exp.size() == 0) check("mem_rd_unexpected", mem_addr, 27'h0 - 27'h1);
        else check("mem_rd_addr", mem_addr, rd_exp.pop_front());
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    prev_pend = (mem_req === 1'b1) && !mem_ack && !rst_draw;
    prev_addr = mem_addr;
  end

  // ---------------- line-buffer write scoreboard ----------------
  logic [18:0] exp_q [$];
  int          n_wr = 0;
  logic [18:0] first_wr = '0;
  logic [18:0] last_wr  = '0;

  always begin
    @(posedge clk_draw);
    #1;
    if (lb_we === 1'b1) begin
      if (n_wr == 0) first_wr = {lb_addr, lb_data};
      last_wr = {lb_addr, lb_data};
      n_wr++;
      if (exp_q.size() == 0) check("lb_write_unexpected", {lb_addr, lb_data}, 19'h7FFFF);
      else check("lb_write", {lb_addr, lb_data}, exp_q.pop_front());
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        flip;
    logic [4:0]  tc;
    logic [26:0] tmap;
    logic [10:0] lb;
    logic [26:0] bmp;
    logic [15:0] map_w0;
    logic [15:0] map_w1;
    logic [31:0] row0;
    logic [31:0] row1;
    int          wait_cyc;
    int          exp_n;
    logic [18:0] exp_first;
    logic [18:0] exp_last;
  } vec_t;

  vec_t vecs [6];

  // Reference behaviour of one sprite: reads and visible writes in order.
  task automatic build_expected(input vec_t v);
    int          ti;
    int          p;
    int          idx;
    int          a;
    logic [26:0] ma;
    logic [26:0] ba;
    logic [15:0] w;
    logic [31:0] row;
    logic [3:0]  pix;
    for (int t = 0; t < int'(v.tc); t++) begin
      ti  = v.flip ? (int'(v.tc) - 1 - t) : t;
      ma  = v.tmap + 27'(ti);
      w   = rd_mem(ma)[15:0];
      ba  = v.bmp + 27'(w[11:0]);
      row = rd_mem(ba);
      rd_exp.push_back(ma);
      rd_exp.push_back(ba);
      for (int c = 0; c < 16; c++) begin
        p   = c / 2;
        idx = v.flip ? 7 - p : p;
        pix = row[idx*4 +: 4];
        a   = (int'(v.lb) + 16*t + c) % 2048;
        if (pix != 4'h0 && a < LBW) exp_q.push_back({11'(a), w[15:12], pix});
      end
    end
  endtask

  task automatic load_vec(input vec_t v);
    tilemap_entry_t e0, e1;
    for (int i = 0; i < 512; i++) m_valid[i] = 1'b0;
    m_valid[0] = 1'b1;
    m_tmap[0]  = '{x_flip: v.flip, tile_count: v.tc, tilemap_addr: v.tmap};
    m_bmap[0]  = '{lb_addr: v.lb, tile_bitmap_addr: v.bmp};
    mem_words.delete();
    e0 = tilemap_entry_t'(v.map_w0);
    e1 = tilemap_entry_t'(v.map_w1);
    mem_words[v.tmap]          = {16'h0, v.map_w0};
    mem_words[v.tmap + 27'd1]  = {16'h0, v.map_w1};
    mem_words[v.bmp + 27'(e0.tile)] = v.row0;
    mem_words[v.bmp + 27'(e1.tile)] = v.row1;
    mem_wait = v.wait_cyc;
  endtask

  task automatic pulse_line();
    @(negedge clk_draw);
    line = 1'b1;
    @(negedge clk_draw);
    line = 1'b0;
  endtask

  task automatic wait_state(input fetch_state_t st, input int budget, input string name);
    int k = 0;
    while (state_dbg != st && k < budget) begin
      @(negedge clk_draw);
      k++;
    end
    check(name, (k < budget), 1'b1);
  endtask

  task automatic run_vector(input int i);
    string pfx;
    pfx = $sformatf("v%0d_", i);
    load_vec(vecs[i]);
    build_expected(vecs[i]);
    n_wr = 0;
    pulse_line();
    wait_state(FS_DONE, 3000, {pfx, "done_timeout"});
    check({pfx, "writes_left"}, exp_q.size(), 0);
    check({pfx, "reads_left"}, rd_exp.size(), 0);
    check({pfx, "n_writes"}, n_wr, vecs[i].exp_n);
    check({pfx, "busy_done"}, busy, 1'b0);
    if (vecs[i].exp_n > 0) begin
      check({pfx, "first_write"}, first_wr, vecs[i].exp_first);
      check({pfx, "last_write"}, last_wr, vecs[i].exp_last);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 512; i++) begin
      m_valid[i] = 1'b0;
      m_tmap[i]  = '0;
      m_bmap[i]  = '0;
    end
    //           flip tc  tmap          lb    bmp       map_w0    map_w1    row0           row1          wait n   first              last
    vecs[0] = '{1'b0, 5'd1, 27'h100,     11'd100,  27'h200, 16'h3005, 16'h0000, 32'h87654321, 32'h0,        0, 16, {11'd100, 8'h31}, {11'd115, 8'h38}};
    vecs[1] = '{1'b1, 5'd2, 27'h40,      11'd200,  27'h300, 16'h2003, 16'h3002, 32'h11111111, 32'h87654321, 2, 32, {11'd200, 8'h38}, {11'd231, 8'h21}};
    vecs[2] = '{1'b0, 5'd1, 27'h500,     11'd632,  27'h600, 16'h5001, 16'h0000, 32'h00000010, 32'h0,        1, 2,  {11'd634, 8'h51}, {11'd635, 8'h51}};
    vecs[3] = '{1'b0, 5'd1, 27'h700,     11'd2040, 27'h800, 16'h7004, 16'h0000, 32'h22222222, 32'h0,        3, 8,  {11'd0,   8'h72}, {11'd7,   8'h72}};
    vecs[4] = '{1'b0, 5'd2, 27'h7FFFFFF, 11'd10,   27'h10,  16'h4001, 16'h4001, 32'h00000009, 32'h00000009, 0, 4,  {11'd10,  8'h49}, {11'd27,  8'h49}};
    vecs[5] = '{1'b0, 5'd0, 27'h900,     11'd0,    27'h0,   16'h1001, 16'h0000, 32'hFFFFFFFF, 32'h0,        0, 0,  19'h0,            19'h0};

    // Reset state
    #1 rst_draw = 1'b1;
    #1;
    check("rst_state", state_dbg, FS_IDLE);
    check("rst_sprite_index", sprite_index, 9'd0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 27'd0);
    check("rst_lb_we", lb_we, 1'b0);
    check("rst_lb_addr", lb_addr, 11'd0);
    check("rst_lb_data", lb_data, 8'd0);
    check("rst_busy", busy, 1'b0);
`ifdef SPRITE_LINE_FETCHER_OVERRUN_EN
    check("rst_overrun", overrun, 1'b0);
    check("rst_overrun_count", overrun_count, 16'd0);
`endif
    repeat (3) @(negedge clk_draw);
    rst_draw = 1'b0;
    @(negedge clk_draw);

    for (int i = 0; i < 6; i++) run_vector(i);

    // Empty line: nothing valid, walk ends after one LATCH
    for (int i = 0; i < 512; i++) m_valid[i] = 1'b0;
    req_seen = 1'b0;
    pulse_line();
    check("empty_sel", state_dbg, FS_SEL);
    check("empty_busy_sel", busy, 1'b1);
    @(negedge clk_draw);
    check("empty_latch", state_dbg, FS_LATCH);
    @(negedge clk_draw);
    check("empty_done", state_dbg, FS_DONE);
    check("empty_busy_done", busy, 1'b0);
    repeat (4) @(negedge clk_draw);
    check("empty_still_done", state_dbg, FS_DONE);
    check("empty_no_req", req_seen, 1'b0);
    check("empty_index", sprite_index, 9'd0);

    // Abort: line arrives while the bitmap read is held off
    load_vec(vecs[0]);
    block_en   = 1'b1;
    block_addr = 27'h205;
    rd_exp.push_back(27'h100);
    n_wr = 0;
    pulse_line();
    wait_state(FS_BMP, 100, "abort_reach_bmp");
    repeat (3) @(negedge clk_draw);
    check("abort_req_held", mem_req, 1'b1);
    check("abort_addr_held", mem_addr, 27'h205);
    check("abort_no_writes", n_wr, 0);
    check("abort_rd_done", rd_exp.size(), 0);
    line = 1'b1;
    block_en = 1'b0;
    build_expected(vecs[0]);
    @(negedge clk_draw);
    line = 1'b0;
    check("abort_req_drop", mem_req, 1'b0);
    check("abort_index", sprite_index, 9'd0);
    check("abort_state", state_dbg, FS_SEL);
    check("abort_lb_we", lb_we, 1'b0);
`ifdef SPRITE_LINE_FETCHER_OVERRUN_EN
    check("abort_overrun_pulse", overrun, 1'b1);
    @(negedge clk_draw);
    check("abort_overrun_clear", overrun, 1'b0);
    check("abort_overrun_count", overrun_count, 16'd1);
`endif
    wait_state(FS_DONE, 3000, "abort_rewalk_timeout");
    check("abort_writes_left", exp_q.size(), 0);
    check("abort_reads_left", rd_exp.size(), 0);
    check("abort_n_writes", n_wr, 16);

    // Reset in the middle of DRAW
    load_vec(vecs[0]);
    build_expected(vecs[0]);
    pulse_line();
    wait_state(FS_DRAW, 100, "rstdraw_reach_draw");
    repeat (4) @(negedge clk_draw);
    check("rstdraw_we_before", lb_we, 1'b1);
    #2 rst_draw = 1'b1;
    #1;
    check("rstdraw_lb_we", lb_we, 1'b0);
    check("rstdraw_mem_req", mem_req, 1'b0);
    check("rstdraw_busy", busy, 1'b0);
    check("rstdraw_state", state_dbg, FS_IDLE);
    check("rstdraw_index", sprite_index, 9'd0);
    exp_q.delete();
    rd_exp.delete();
    @(negedge clk_draw);
    rst_draw = 1'b0;
    repeat (3) @(negedge clk_draw);
    check("rstdraw_idle_after", state_dbg, FS_IDLE);
`ifdef SPRITE_LINE_FETCHER_OVERRUN_EN
    check("rstdraw_overrun_count", overrun_count, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
